skin_frame_ctrl: RTL and testbench

SKIN_FRAME_CTRL -- requirements
Module: skin_frame_ctrl

---
 rtl/skin_frame_ctrl_pkg.sv | 30 +++
 rtl/skin_frame_ctrl_threshold.sv | 45 ++++
 rtl/skin_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_skin_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_frame_ctrl_pkg.sv
// Shared constants for the skin-frame controller.
// FSM encoding, counter widths and YCbCr skin thresholds.
package skin_frame_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int COL_W = 9;
  localparam int ROW_W = 8;
  localparam int CNT_W = 17;

  localparam logic [7:0] LUMA_MIN = 8'd80;
  localparam logic [7:0] CB_MIN   = 8'd125;
  localparam logic [7:0] CB_MAX   = 8'd180;
  localparam logic [7:0] CR_MIN   = 8'd190;
  localparam logic [7:0] CR_MAX   = 8'd225;

  function automatic logic is_skin(
    input logic [7:0] y,
    input logic [7:0] cb,
    input logic [7:0] cr
  );
    return (y > LUMA_MIN) &&
           (cb > CB_MIN) && (cb < CB_MAX) &&
           (cr > CR_MIN) && (cr < CR_MAX);
  endfunction

endpackage

// File: rtl/skin_frame_ctrl_threshold.sv
// Registered per-pixel skin classifier, one cycle of latency.
// Pixel position and valid travel alongside the hit flag.
module skin_threshold
  import skin_frame_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [COL_W-1:0] i_col,
  input  logic [ROW_W-1:0] i_row,
  input  logic [7:0]       i_luma,
  input  logic [7:0]       i_cb,
  input  logic [7:0]       i_cr,
  output logic             o_valid,
  output logic             o_hit,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row
);

  logic             r_valid;
  logic             r_hit;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Classify the transferred pixel and delay its position by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_valid <= i_valid;
      r_hit   <= i_valid && is_skin(i_luma, i_cb, i_cr);
      r_col   <= i_col;
      r_row   <= i_row;
    end
  end

  assign o_valid = r_valid;
  assign o_hit   = r_hit;
  assign o_col   = r_col;
  assign o_row   = r_row;

endmodule

// File: rtl/skin_frame_ctrl.sv
// Frame scan controller: walks one YCbCr frame in raster order,
// counts skin pixels and tracks their bounding box.
module skin_frame_ctrl
  import skin_frame_ctrl_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int MIN_SKIN = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       luma_ch,
  input  logic [7:0]       cb_ch,
  input  logic [7:0]       cr_ch,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] skin_count,
  output logic [COL_W-1:0] x_min,
  output logic [COL_W-1:0] x_max,
  output logic [ROW_W-1:0] y_min,
  output logic [ROW_W-1:0] y_max,
  output logic             gesture_present
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_SKIN);

  logic [1:0]       r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic [CNT_W-1:0] r_cnt;
  logic [COL_W-1:0] r_xmin, r_xmax;
  logic [ROW_W-1:0] r_ymin, r_ymax;

  logic             r_done;
  logic [CNT_W-1:0] r_out_cnt;
  logic [COL_W-1:0] r_out_xmin, r_out_xmax;
  logic [ROW_W-1:0] r_out_ymin, r_out_ymax;
  logic             r_out_gest;

  logic             w_xfer;
  logic             w_go;
  logic             w_hv;
  logic             w_hit;
  logic [COL_W-1:0] w_hcol;
  logic [ROW_W-1:0] w_hrow;

  assign pix_ready = (r_state == ST_SCAN);
  assign busy      = (r_state != ST_IDLE);
  assign w_xfer    = pix_valid && pix_ready;
  assign w_go      = (r_state == ST_IDLE) && start;

  skin_threshold u_thr (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_xfer),
    .i_col   (r_col),
    .i_row   (r_row),
    .i_luma  (luma_ch),
    .i_cb    (cb_ch),
    .i_cr    (cr_ch),
    .o_valid (w_hv),
    .o_hit   (w_hit),
    .o_col   (w_hcol),
    .o_row   (w_hrow)
  );

  // State machine and raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ST_SCAN: begin
          if (w_xfer) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                r_state <= ST_DRAIN;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Skin count and bounding box; first hit seeds the box
  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      r_cnt  <= '0;
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (w_hv && w_hit) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '0) begin
        r_xmin <= w_hcol;
        r_xmax <= w_hcol;
        r_ymin <= w_hrow;
        r_ymax <= w_hrow;
      end else begin
        if (w_hcol < r_xmin) r_xmin <= w_hcol;
        if (w_hcol > r_xmax) r_xmax <= w_hcol;
        if (w_hrow < r_ymin) r_ymin <= w_hrow;
        if (w_hrow > r_ymax) r_ymax <= w_hrow;
      end
    end
  end

  // Publish results once per frame and pulse done alongside them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_out_cnt  <= '0;
      r_out_xmin <= '0;
      r_out_xmax <= '0;
      r_out_ymin <= '0;
      r_out_ymax <= '0;
      r_out_gest <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_out_cnt  <= r_cnt;
        r_out_xmin <= r_xmin;
        r_out_xmax <= r_xmax;
        r_out_ymin <= r_ymin;
        r_out_ymax <= r_ymax;
        r_out_gest <= (r_cnt >= CNT_MIN);
      end
    end
  end

  assign done            = r_done;
  assign skin_count      = r_out_cnt;
  assign x_min           = r_out_xmin;
  assign x_max           = r_out_xmax;
  assign y_min           = r_out_ymin;
  assign y_max           = r_out_ymax;
  assign gesture_present = r_out_gest;

endmodule

// File: tb/tb_skin_frame_ctrl.sv
// Directed bench for skin_frame_ctrl on an 8x4 frame.
// Each task drives one scenario and checks hand-computed results.
module tb_skin_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  luma_ch = '0;
  logic [7:0]  cb_ch = '0;
  logic [7:0]  cr_ch = '0;
  logic        busy;
  logic        done;
  logic [16:0] skin_count;
  logic [8:0]  x_min, x_max;
  logic [7:0]  y_min, y_max;
  logic        gesture_present;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skin_frame_ctrl #(
    .IMG_W    (8),
    .IMG_H    (4),
    .MIN_SKIN (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .luma_ch         (luma_ch),
    .cb_ch           (cb_ch),
    .cr_ch           (cr_ch),
    .busy            (busy),
    .done            (done),
    .skin_count      (skin_count),
    .x_min           (x_min),
    .x_max           (x_max),
    .y_min           (y_min),
    .y_max           (y_max),
    .gesture_present (gesture_present)
  );

  function automatic logic [23:0] pix(int mode, int c, int r, int idx);
    logic [23:0] p;
    p = 24'h0;
    case (mode)
      0: p = {8'd100, 8'd150, 8'd200};
      1: if ((c == 3 && r == 1) || (c == 5 && r == 2))
           p = {8'd100, 8'd150, 8'd200};
      2: case (idx % 5)
           0: p = {8'd80,  8'd150, 8'd200};
           1: p = {8'd100, 8'd125, 8'd200};
           2: p = {8'd100, 8'd180, 8'd200};
           3: p = {8'd100, 8'd150, 8'd190};
           default: p = {8'd100, 8'd150, 8'd225};
         endcase
      default: case (idx % 5)
           0: p = {8'd81,  8'd150, 8'd200};
           1: p = {8'd100, 8'd126, 8'd200};
           2: p = {8'd100, 8'd179, 8'd200};
           3: p = {8'd100, 8'd150, 8'd191};
           default: p = {8'd100, 8'd150, 8'd224};
         endcase
    endcase
    return p;
  endfunction

  // Runs one frame; lat is the cycle (start = cycle 0) where done is seen
  task automatic run_frame(input int mode, input int toggle,
                           input int xstart, input int abort_n,
                           output int lat, output int rdy,
                           output int mid, output int nd);
    int c, r, n;
    c = 0; r = 0; n = 0;
    lat = -1; rdy = 0; mid = -1; nd = 0;
    @(negedge clk);
    start = 1'b1;
    pix_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == xstart);
      if (done) begin
        nd++;
        if (lat < 0) lat = k;
      end
      if (k == 10) mid = int'(skin_count);
      if (lat >= 0 && k >= lat + 5) break;
      if (abort_n > 0 && n == abort_n) begin
        rst = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      pix_valid = (toggle != 0) ? (k % 2 == 0) : 1'b1;
      {luma_ch, cb_ch, cr_ch} = pix(mode, c, r, n);
      if (pix_ready) rdy++;
      if (pix_valid && pix_ready) begin
        n++;
        c++;
        if (c == 8) begin
          c = 0;
          r++;
        end
      end
    end
    pix_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_ready, busy, done, gesture_present} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000",
               {pix_ready, busy, done, gesture_present});
    end
    checks++;
    if ({skin_count, x_min, x_max, y_min, y_max} !== '0) begin
      errors++;
      $display("FAIL reset_results cnt=%0d box=%0d,%0d,%0d,%0d want 0",
               skin_count, x_min, x_max, y_min, y_max);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start busy=%b want=0", busy);
    end
  endtask

  task automatic test_all_skin();
    int lat, rdy, mid, nd;
    run_frame(0, 0, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (lat !== 35) begin
      errors++;
      $display("FAIL all_latency got=%0d want=35", lat);
    end
    checks++;
    if (rdy !== 32) begin
      errors++;
      $display("FAIL all_ready_cycles got=%0d want=32", rdy);
    end
    checks++;
    if (skin_count !== 17'd32) begin
      errors++;
      $display("FAIL all_count got=%0d want=32", skin_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {9'd0, 9'd7, 8'd0, 8'd3}) begin
      errors++;
      $display("FAIL all_box got=%0d,%0d,%0d,%0d want=0,7,0,3",
               x_min, x_max, y_min, y_max);
    end
    checks++;
    if (gesture_present !== 1'b1) begin
      errors++;
      $display("FAIL all_gesture got=%b want=1", gesture_present);
    end
  endtask

  task automatic test_two_pixels();
    int lat, rdy, mid, nd;
    run_frame(1, 0, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (mid !== 32) begin
      errors++;
      $display("FAIL hold_during_scan got=%0d want=32", mid);
    end
    checks++;
    if (skin_count !== 17'd2) begin
      errors++;
      $display("FAIL two_count got=%0d want=2", skin_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {9'd3, 9'd5, 8'd1, 8'd2}) begin
      errors++;
      $display("FAIL two_box got=%0d,%0d,%0d,%0d want=3,5,1,2",
               x_min, x_max, y_min, y_max);
    end
    checks++;
    if (gesture_present !== 1'b0) begin
      errors++;
      $display("FAIL two_gesture got=%b want=0", gesture_present);
    end
  endtask

  task automatic test_boundary();
    int lat, rdy, mid, nd;
    run_frame(2, 0, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (skin_count !== 17'd0) begin
      errors++;
      $display("FAIL bound_count got=%0d want=0", skin_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max, gesture_present} !== '0) begin
      errors++;
      $display("FAIL bound_box got=%0d,%0d,%0d,%0d g=%b want 0",
               x_min, x_max, y_min, y_max, gesture_present);
    end
    run_frame(3, 0, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (skin_count !== 17'd32) begin
      errors++;
      $display("FAIL inside_count got=%0d want=32", skin_count);
    end
  endtask

  task automatic test_toggle();
    int lat, rdy, mid, nd;
    run_frame(0, 1, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (lat !== 67) begin
      errors++;
      $display("FAIL toggle_latency got=%0d want=67", lat);
    end
    checks++;
    if (skin_count !== 17'd32) begin
      errors++;
      $display("FAIL toggle_count got=%0d want=32", skin_count);
    end
  endtask

  task automatic test_start_during_scan();
    int lat, rdy, mid, nd;
    run_frame(0, 0, 5, 0, lat, rdy, mid, nd);
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL restart_done_pulses got=%0d want=1", nd);
    end
    checks++;
    if (lat !== 35) begin
      errors++;
      $display("FAIL restart_latency got=%0d want=35", lat);
    end
    checks++;
    if (rdy !== 32) begin
      errors++;
      $display("FAIL restart_ready_cycles got=%0d want=32", rdy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rdy, mid, nd, ndone;
    run_frame(0, 0, 0, 10, lat, rdy, mid, nd);
    checks++;
    if ({busy, pix_ready, skin_count, gesture_present} !== '0) begin
      errors++;
      $display("FAIL abort_state busy=%b rdy=%b cnt=%0d g=%b want 0",
               busy, pix_ready, skin_count, gesture_present);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d want=0", ndone);
    end
    run_frame(0, 0, 0, 0, lat, rdy, mid, nd);
    checks++;
    if (skin_count !== 17'd32 || lat !== 35) begin
      errors++;
      $display("FAIL abort_second_frame cnt=%0d lat=%0d want=32,35",
               skin_count, lat);
    end
  endtask

  initial begin
    test_reset();
    test_all_skin();
    test_two_pixels();
    test_boundary();
    test_toggle();
    test_start_during_scan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
